// File: rtl/uart_rx_engine.sv
// UART receiver: oversampled start/data/parity/stop decode into a small RX FIFO with irq.
// Latency: push at the middle of the last stop bit; valid_o rises one cycle later.
// Backpressure: valid_o/ready_i pop; a frame arriving into a full FIFO is dropped and flagged by overrun_o.
//
// Ports: clk_i/arst_ni clock and async active-low reset; rx_i raw serial line;
//   clk_en_i gates the receiver; flush_i empties the FIFO; clk_div_i clocks per oversample tick;
//   data_bits_i/parity_en_i/parity_type_i/stop_bits_i frame format; rx_int_en_i/thresh_i irq setup;
//   data_o/perr_o/ferr_o/brk_o/valid_o FIFO head with ready_i pop; count_o fill level;
//   overrun_o drop pulse; irq_o registered interrupt.
module uart_rx_engine #(
    parameter  int FIFO_DEPTH   = 8,
    parameter  int OVERSAMPLE   = 16,
    parameter  int TIMEOUT_BITS = 40,
    localparam int CW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          rx_i,
    input  logic          clk_en_i,
    input  logic          flush_i,
    input  logic [31:0]   clk_div_i,
    input  logic [1:0]    data_bits_i,
    input  logic          parity_en_i,
    input  logic          parity_type_i,
    input  logic          stop_bits_i,
    input  logic          rx_int_en_i,
    input  logic [CW-1:0] thresh_i,
    output logic [7:0]    data_o,
    output logic          perr_o,
    output logic          ferr_o,
    output logic          brk_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [CW-1:0] count_o,
    output logic          overrun_o,
    output logic          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } entry_t;

    // ---------------- synchronizer + edge history ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- oversample tick ----------------
    logic [31:0] div_cnt_q, div_cnt_d, div_last;
    logic        tick;
    always_comb begin
        div_last  = (clk_div_i == 32'd0) ? 32'd0 : clk_div_i - 32'd1;
        // >= rather than == so a live shrink of clk_div_i cannot strand the counter
        tick      = clk_en_i && (div_cnt_q >= div_last);
        div_cnt_d = (!clk_en_i || tick) ? 32'd0 : div_cnt_q + 32'd1;
    end

    // ---------------- frame FSM ----------------
    state_t        state_q, state_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    vote_q, vote_d;
    logic          perr_q, perr_d, ferr_q, ferr_d, zero_q, zero_d;
    logic          maj, decide, wrap, push_req;
    entry_t        push_entry;

    always_comb begin
        state_d  = state_q;
        samp_d   = samp_q;
        bit_d    = bit_q;
        data_d   = data_q;
        vote_d   = vote_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        zero_d   = zero_q;
        push_req = 1'b0;

        maj    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) | (vote_q[1] & rx_sync_q);
        decide = tick && (samp_q == S_HI);
        wrap   = tick && (samp_q == S_LAST);
        // Entry reflects the last stop bit being decided this cycle.
        push_entry = '{brk: zero_q & ~maj, ferr: ferr_q | ~maj, perr: perr_q, data: data_q};

        if (state_q != IDLE && tick) begin
            samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
            if (samp_q == S_LO)  vote_d[0] = rx_sync_q;
            if (samp_q == S_MID) vote_d[1] = rx_sync_q;
        end

        case (state_q)
            IDLE: begin
                samp_d = '0;
                bit_d  = '0;
                // Falling edge, not level: after a break the line must return high
                // before the next frame can start.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    data_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    zero_d  = 1'b1;
                end
            end
            START: begin
                if (decide && maj)  state_d = IDLE;
                else if (wrap)      state_d = DATA;
            end
            DATA: begin
                if (decide) begin
                    data_d[bit_q] = maj;
                    if (maj) zero_d = 1'b0;
                end
                if (wrap) begin
                    if (bit_q == {1'b0, data_bits_i} + 3'd4)
                        state_d = parity_en_i ? PARITY : STOP1;
                    else
                        bit_d = bit_q + 3'd1;
                end
            end
            PARITY: begin
                if (decide) begin
                    perr_d = ((^data_q) ^ maj) != parity_type_i;
                    if (maj) zero_d = 1'b0;
                end
                if (wrap) state_d = STOP1;
            end
            STOP1: begin
                if (decide) begin
                    if (!stop_bits_i) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        if (!maj) ferr_d = 1'b1;
                        else      zero_d = 1'b0;
                    end
                end
                if (wrap && stop_bits_i) state_d = STOP2;
            end
            STOP2: begin
                if (decide) begin
                    push_req = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!clk_en_i) begin
            state_d  = IDLE;
            push_req = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            div_cnt_q <= '0;
            state_q   <= IDLE;
            samp_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            vote_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            vote_q    <= vote_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            zero_q    <= zero_d;
        end
    end

    // ---------------- RX FIFO ----------------
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          full, pop, push_ok, overrun_q;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;
    assign push_ok = push_req && (!full || pop);
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= push_entry;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= !flush_i && push_req && full && !pop;
            if (flush_i) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (push_ok) wr_q <= wr_q + 1'b1;
                if (pop)     rd_q <= rd_q + 1'b1;
                if (push_ok && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push_ok) count_q <= count_q - 1'b1;
            end
        end
    end

    assign data_o    = valid_o ? head.data : 8'h00;
    assign perr_o    = valid_o & head.perr;
    assign ferr_o    = valid_o & head.ferr;
    assign brk_o     = valid_o & head.brk;
    assign count_o   = count_q;
    assign overrun_o = overrun_q;

    // ---------------- receive timeout + irq ----------------
    logic [SW-1:0] tsamp_q, tsamp_d;
    logic [TW-1:0] tbits_q, tbits_d;
    logic          tout_q, tout_d, tclr, irq_q;

    always_comb begin
        tsamp_d = tsamp_q;
        tbits_d = tbits_q;
        tout_d  = tout_q;
        tclr    = push_req || pop || flush_i || (state_q != IDLE) || (count_q == '0);
        if (tclr) begin
            tsamp_d = '0;
            tbits_d = '0;
            tout_d  = 1'b0;
        end else if (tick && !tout_q) begin
            if (tsamp_q == S_LAST) begin
                tsamp_d = '0;
                tbits_d = tbits_q + 1'b1;
                if (tbits_q == TW'(TIMEOUT_BITS - 1)) tout_d = 1'b1;
            end else begin
                tsamp_d = tsamp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tsamp_q <= '0;
            tbits_q <= '0;
            tout_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            tsamp_q <= tsamp_d;
            tbits_q <= tbits_d;
            tout_q  <= tout_d;
            irq_q   <= rx_int_en_i && (((thresh_i != '0) && (count_q >= thresh_i)) || tout_q);
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frames are driven bit by bit at 16 clocks/bit,
// expected FIFO entries are queued when each frame is sent and compared on every pop.
module tb_uart_rx_engine;
    localparam int CW = $clog2(8 + 1);

    logic          clk = 1'b0;
    logic          arst_ni;
    logic          rx_i, clk_en_i, flush_i;
    logic [31:0]   clk_div_i;
    logic [1:0]    data_bits_i;
    logic          parity_en_i, parity_type_i, stop_bits_i, rx_int_en_i;
    logic [CW-1:0] thresh_i;
    logic [7:0]    data_o;
    logic          perr_o, ferr_o, brk_o, valid_o, ready_i, overrun_o, irq_o;
    logic [CW-1:0] count_o;

    uart_rx_engine dut (
        .clk_i(clk), .arst_ni(arst_ni), .rx_i(rx_i), .clk_en_i(clk_en_i),
        .flush_i(flush_i), .clk_div_i(clk_div_i), .data_bits_i(data_bits_i),
        .parity_en_i(parity_en_i), .parity_type_i(parity_type_i),
        .stop_bits_i(stop_bits_i), .rx_int_en_i(rx_int_en_i), .thresh_i(thresh_i),
        .data_o(data_o), .perr_o(perr_o), .ferr_o(ferr_o), .brk_o(brk_o),
        .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o),
        .overrun_o(overrun_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [10:0] sb[$];     // {brk, ferr, perr, data}
    int cyc_cnt = 0;
    int valid_rise = -1;
    int ovr_cnt = 0;
    logic valid_prev = 1'b0;
    int start_cyc;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (valid_o && !valid_prev) valid_rise <= cyc_cnt;
        valid_prev <= valid_o;
        if (overrun_o) ovr_cnt <= ovr_cnt + 1;
    end

    // Scoreboard: every pop the DUT performs must match the oldest expected entry.
    always @(negedge clk) begin
        logic [10:0] got, exp;
        if (arst_ni && valid_o && ready_i && !flush_i) begin
            got = {brk_o, ferr_o, perr_o, data_o};
            checks++;
            assert (sb.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_pop observed=%h expected=<none>", got);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checks++;
                assert (got === exp)
                else begin
                    errors++;
                    $error("FAIL pop_entry observed=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic two_stop);
        start_cyc = cyc_cnt;
        rx_i = 1'b0;
        bit_time();
        for (int i = 0; i < nbits; i++) begin
            rx_i = d[i];
            bit_time();
        end
        if (par_en) begin
            rx_i = par_bit;
            bit_time();
        end
        rx_i = 1'b1;
        bit_time();
        if (two_stop) bit_time();
        bit_time();
        bit_time();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        ready_i = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            if (!valid_o) break;
            n++;
        end
        ready_i = 1'b0;
        check({tag, "_drained"}, n < 40, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ovr_base;
        arst_ni = 1'b0; rx_i = 1'b1; clk_en_i = 1'b1; flush_i = 1'b0; clk_div_i = 32'd1;
        data_bits_i = 2'd3; parity_en_i = 1'b0; parity_type_i = 1'b0; stop_bits_i = 1'b0;
        rx_int_en_i = 1'b0; thresh_i = '0; ready_i = 1'b0;

        #23;
        check("rst_valid", valid_o, 0);
        check("rst_count", count_o, 0);
        check("rst_data", data_o, 0);
        check("rst_flags", {perr_o, ferr_o, brk_o}, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_irq", irq_o, 0);
        @(negedge clk);
        arst_ni = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 8N1 0xA5: push at mid stop bit; valid 157 clocks after start-bit edge
        sb.push_back({3'b000, 8'hA5});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
        check("a5_latency", valid_rise - start_cyc, 157);
        check("a5_count", count_o, 1);
        drain("a5");

        // 7O1 0x41 with wrong parity bit (correct odd parity would be 1)
        data_bits_i = 2'd2; parity_en_i = 1'b1; parity_type_i = 1'b1;
        sb.push_back({3'b001, 8'h41});
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b0);
        // 5N1 0x1F
        data_bits_i = 2'd0; parity_en_i = 1'b0;
        sb.push_back({3'b000, 8'h1F});
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0);
        // 8E2 0x03 with correct even parity
        data_bits_i = 2'd3; parity_en_i = 1'b1; parity_type_i = 1'b0; stop_bits_i = 1'b1;
        sb.push_back({3'b000, 8'h03});
        send_frame(8'h03, 8, 1'b1, 1'b0, 1'b1);
        check("fmt_count", count_o, 3);
        drain("fmt");
        parity_en_i = 1'b0; stop_bits_i = 1'b0;

        // Break: line low for 12 bit times -> exactly one brk/ferr entry
        sb.push_back({3'b110, 8'h00});
        rx_i = 1'b0;
        repeat (12) bit_time();
        rx_i = 1'b1;
        repeat (3) bit_time();
        check("brk_count", count_o, 1);
        drain("brk");

        // Nine frames into an 8-deep FIFO with no reader
        ovr_base = ovr_cnt;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) sb.push_back({3'b000, 8'(8'h10 + 8'(i * 23))});
            send_frame(8'(8'h10 + 8'(i * 23)), 8, 1'b0, 1'b0, 1'b0);
        end
        check("ovr_count", count_o, 8);
        check("ovr_pulses", ovr_cnt - ovr_base, 1);
        drain("ovr");

        // 4-clock glitch on idle line: false start, nothing pushed
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (3) bit_time();
        check("glitch_count", count_o, 0);
        check("glitch_valid", valid_o, 0);

        // Receive timeout interrupt
        rx_int_en_i = 1'b1;
        sb.push_back({3'b000, 8'h5A});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
        check("tout_irq_early", irq_o, 0);
        repeat (40) bit_time();
        check("tout_irq_set", irq_o, 1);
        drain("tout");
        repeat (2) @(posedge clk);
        #1;
        check("tout_irq_clr", irq_o, 0);

        // Threshold interrupt at 2 entries
        thresh_i = CW'(2);
        sb.push_back({3'b000, 8'hC3});
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0);
        check("thr_irq_below", irq_o, 0);
        sb.push_back({3'b000, 8'h3C});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        check("thr_irq_at", irq_o, 1);
        drain("thr");
        repeat (2) @(posedge clk);
        #1;
        check("thr_irq_clr", irq_o, 0);
        thresh_i = '0;
        rx_int_en_i = 1'b0;

        // Flush coincident with push and pop: one stored entry, frame lands as flush hits
        sb.push_back({3'b000, 8'h77});
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0);
        check("fl_pre_count", count_o, 1);
        fork
            send_frame(8'h99, 8, 1'b0, 1'b0, 1'b0);
            begin
                repeat (156) @(posedge clk);
                #1;
                flush_i = 1'b1;
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
                ready_i = 1'b0;
                sb.delete();
                @(negedge clk);
                check("fl_count", count_o, 0);
                check("fl_valid", valid_o, 0);
            end
        join
        check("fl_count_later", count_o, 0);
        sb.push_back({3'b000, 8'h2D});
        send_frame(8'h2D, 8, 1'b0, 1'b0, 1'b0);
        drain("fl_after");

        // Reset mid-frame discards the partial frame; next frame decodes
        fork
            send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0);
            begin
                repeat (80) @(posedge clk);
                #1;
                arst_ni = 1'b0;
                #20;
                arst_ni = 1'b1;
            end
        join
        check("rst_mid_count", count_o, 0);
        sb.push_back({3'b000, 8'hB6});
        send_frame(8'hB6, 8, 1'b0, 1'b0, 1'b0);
        check("rst_mid_after", count_o, 1);
        drain("rst_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
